// File: rtl/mux.sv
// N_IN:1 bit multiplexer with a registered output copy and select-change detection.
// Optional MUX_SEL_COUNT_EN adds a 16-bit saturating count of select changes.
module mux #(
   parameter int N_IN  = 4,
   parameter int SEL_W = $clog2(N_IN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEL_W-1:0] s,
   input  logic [N_IN-1:0]  d,
   output logic             y,
   output logic             y_q,
   output logic             sel_chg,
   output logic [15:0]      chg_cnt
);

   logic [SEL_W-1:0] sel_q;
   logic             sel_diff;

   // N_IN is a power of two, so every select value addresses a real channel.
   assign y        = d[s];
   assign sel_diff = (s != sel_q);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q     <= 1'b0;
         sel_q   <= '0;
         sel_chg <= 1'b0;
      end else begin
         y_q     <= y;
         sel_q   <= s;
         sel_chg <= sel_diff;
      end
   end

`ifdef MUX_SEL_COUNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (sel_diff && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign chg_cnt = cnt_q;
`else
   assign chg_cnt = '0;
`endif

endmodule

// File: tb/tb_mux.sv
// Directed bench for mux: table-driven combinational and registered vectors,
// plus hand-written change-detect, mid-operation reset and saturation sequences.
module tb_mux;

`ifdef MUX_SEL_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct {
      logic [1:0] s;
      logic [3:0] d;
      logic       exp_y;
   } vec_t;

   logic        clk;
   logic        clk_en;
   logic        rst;
   logic [1:0]  s;
   logic [3:0]  d;
   logic        y;
   logic        y_q;
   logic        sel_chg;
   logic [15:0] chg_cnt;

   int n_vec;
   int n_err;

   vec_t vecs [12];

   mux #(.N_IN(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .s       (s),
      .d       (d),
      .y       (y),
      .y_q     (y_q),
      .sel_chg (sel_chg),
      .chg_cnt (chg_cnt)
   );

   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] cnt_exp(input int v);
      return CNT_EN ? 16'(v) : 16'd0;
   endfunction

   initial begin
      n_vec  = 0;
      n_err  = 0;
      clk_en = 1'b0;
      rst    = 1'b0;
      s      = 2'd0;
      d      = 4'd0;

      vecs[0]  = '{2'd0, 4'b0101, 1'b1};
      vecs[1]  = '{2'd1, 4'b0101, 1'b0};
      vecs[2]  = '{2'd2, 4'b0101, 1'b1};
      vecs[3]  = '{2'd3, 4'b0101, 1'b0};
      vecs[4]  = '{2'd3, 4'b1000, 1'b1};
      vecs[5]  = '{2'd0, 4'b1000, 1'b0};
      vecs[6]  = '{2'd1, 4'b0010, 1'b1};
      vecs[7]  = '{2'd2, 4'b1011, 1'b0};
      vecs[8]  = '{2'd2, 4'b0100, 1'b1};
      vecs[9]  = '{2'd0, 4'b0000, 1'b0};
      vecs[10] = '{2'd3, 4'b1111, 1'b1};
      vecs[11] = '{2'd1, 4'b1101, 1'b0};

      // Combinational sweep with the clock idle.
      for (int i = 0; i < 12; i++) begin
         s = vecs[i].s;
         d = vecs[i].d;
         #1;
         check($sformatf("comb_y[%0d]", i), 16'(y), 16'(vecs[i].exp_y));
         #9;
      end

      // Start clock and reset.
      clk_en = 1'b1;
      rst    = 1'b1;
      s      = 2'd0;
      d      = 4'd0;
      tick();
      check("rst_y_q", 16'(y_q), 16'd0);
      check("rst_sel_chg", 16'(sel_chg), 16'd0);
      check("rst_chg_cnt", chg_cnt, 16'd0);

      // Registered path: y_q follows y one edge later.
      rst = 1'b0;
      tick();
      for (int i = 0; i < 12; i++) begin
         s = vecs[i].s;
         d = vecs[i].d;
         #1;
         check($sformatf("reg_y[%0d]", i), 16'(y), 16'(vecs[i].exp_y));
         tick();
         check($sformatf("reg_y_q[%0d]", i), 16'(y_q), 16'(vecs[i].exp_y));
      end

      // Registered-path latency: d=1000, s=11 after a reset pulse.
      rst = 1'b1;
      s   = 2'd0;
      d   = 4'd0;
      tick();
      rst = 1'b0;
      d   = 4'b1000;
      s   = 2'd3;
      #1;
      check("lat_y_q_before", 16'(y_q), 16'd0);
      check("lat_y", 16'(y), 16'd1);
      tick();
      check("lat_y_q_after", 16'(y_q), 16'd1);

      // Change detect: reset with s=00, hold s=01 three cycles, then s=10.
      rst = 1'b1;
      s   = 2'd0;
      d   = 4'b0101;
      tick();
      rst = 1'b0;
      s   = 2'd1;
      tick();
      check("cd_pulse1", 16'(sel_chg), 16'd1);
      check("cd_cnt1", chg_cnt, cnt_exp(1));
      tick();
      check("cd_hold1", 16'(sel_chg), 16'd0);
      tick();
      check("cd_hold2", 16'(sel_chg), 16'd0);
      check("cd_cnt_hold", chg_cnt, cnt_exp(1));
      s = 2'd2;
      tick();
      check("cd_pulse2", 16'(sel_chg), 16'd1);
      check("cd_cnt2", chg_cnt, cnt_exp(2));
      tick();
      check("cd_pulse2_end", 16'(sel_chg), 16'd0);
      check("cd_cnt2_hold", chg_cnt, cnt_exp(2));

      // Mid-operation reset: five changes, then rst with a coincident select change.
      rst = 1'b1;
      s   = 2'd0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s = (i % 2 == 0) ? 2'd1 : 2'd2;
         tick();
      end
      check("mr_cnt5", chg_cnt, cnt_exp(5));
      check("mr_pulse", 16'(sel_chg), 16'd1);
      rst = 1'b1;
      s   = 2'd3;
      d   = 4'b1010;
      tick();
      check("mr_cnt0", chg_cnt, 16'd0);
      check("mr_sel_chg0", 16'(sel_chg), 16'd0);
      check("mr_y_q0", 16'(y_q), 16'd0);
      check("mr_y", 16'(y), 16'd1);
      d = 4'b0010;
      #1;
      check("mr_y_follow", 16'(y), 16'd0);
      rst = 1'b0;
      tick();
      check("mr_first_cmp_pulse", 16'(sel_chg), 16'd1);
      check("mr_first_cmp_cnt", chg_cnt, cnt_exp(1));

`ifdef MUX_SEL_COUNT_EN
      // Saturation: 70000 alternating select changes.
      rst = 1'b1;
      s   = 2'd0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 70000; i++) begin
         s = ~s;
         tick();
      end
      check("sat_cnt", chg_cnt, 16'hFFFF);
      for (int i = 0; i < 4; i++) begin
         s = s + 2'd1;
         tick();
      end
      check("sat_hold", chg_cnt, 16'hFFFF);
      check("sat_pulse", 16'(sel_chg), 16'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mux.md
MUX -- requirements
Module: mux

Interface
REQ-001 Parameter: N_IN, 4, number of 1-bit data inputs; SHALL be a power of two, at least 2.
REQ-002 Parameter: SEL_W, $clog2(N_IN) (2 at default), select width; SHALL NOT be overridden independently of N_IN.
REQ-003 Port: clk  input  1  single clock; all sequential logic on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: s  input  SEL_W  select; chooses which bit of d drives y.
REQ-006 Port: d  input  N_IN  data inputs; bit i is channel i.
REQ-007 Port: y  output  1  combinational mux output, equal to d[s].
REQ-008 Port: y_q  output  1  registered copy of y.
REQ-009 Port: sel_chg  output  1  one-cycle pulse when s differs from the previous cycle's sampled s.
REQ-010 Port: chg_cnt  output  16  saturating count of select changes.

Function
REQ-011 y SHALL equal d[s] combinationally, with zero latency, in the same delta as any change of s or d.
REQ-012 y SHALL NOT depend on clk or rst, so that it is valid with clk and rst undriven or tied off.
REQ-013 y SHALL never be X when s and d are known; every select value 0..N_IN-1 is legal.
REQ-014 Example: s=00, d=0101 -> y=1; s=01 -> y=0; s=10 -> y=1; s=11 -> y=0.
REQ-015 y_q SHALL take the value of d[s] at each rising clk edge when rst=0, giving 1-cycle latency.
REQ-016 An internal register sel_q SHALL capture s every cycle when rst=0.
REQ-017 sel_chg SHALL be registered, and SHALL be 1 in the cycle after any edge where s != sel_q and rst=0; otherwise 0.
REQ-018 chg_cnt SHALL increment by 1 on each edge where the select-change condition of REQ-017 holds.
REQ-019 chg_cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-020 The first edge after reset deassertion SHALL compare s against the reset value of sel_q (0).
REQ-021 If rst and a select change coincide, rst SHALL win: no pulse and no count.

Reset
REQ-022 When rst=1 at a rising clk edge, the following SHALL be cleared: y_q=0, sel_q=0, sel_chg=0, chg_cnt=0.
REQ-023 Reset SHALL be synchronous only; no output except y SHALL change without a clk edge.
REQ-024 Asserting rst mid-operation SHALL clear all registered state on that edge, and y SHALL continue to follow d[s].

Configuration
REQ-025 The macro MUX_SEL_COUNT_EN SHALL control the select-change counter.
REQ-026 With MUX_SEL_COUNT_EN defined, chg_cnt SHALL behave per REQ-018 to REQ-021.
REQ-027 Without MUX_SEL_COUNT_EN, chg_cnt SHALL be constant 0 and no counter register SHALL be synthesized.
REQ-028 sel_chg, y and y_q SHALL be unaffected by MUX_SEL_COUNT_EN.

Verification
REQ-029 Combinational sweep, clk idle, d=0101: s=00,01,10,11 at 10-unit steps -> y=1,0,1,0, each within the same step.
REQ-030 Registered path: rst pulse, then d=1000 and s=11 applied before an edge -> y_q=1 after that edge, with y_q=0 before it.
REQ-031 Change detect: hold s=01 for 3 cycles, then s=10 -> sel_chg=1 for exactly one cycle and chg_cnt=2 (reset to 01 counts once).
REQ-032 Saturation, macro defined: force 70000 alternating select changes -> chg_cnt=FFFF and stays there.
REQ-033 Reset mid-operation: chg_cnt=5, assert rst for 1 edge while s changes -> chg_cnt=0, sel_chg=0, y_q=0, and y still equals d[s].
REQ-034 Macro undefined: repeat REQ-031 -> chg_cnt=0 throughout while sel_chg pulses identically.
